// File: rtl/fetch_redirect_ctrl.sv
// Redirect sequencer for the IF stage: arbitrates exception/JR/branch, holds the winner across STALL, runs post-exception flush.
// Optional macro REDIRECT_ALIGN_CHECK_EN traps misaligned branch/JR targets as exceptions.
module fetch_redirect_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        BranchReq_IN,
    input  logic [31:0] BranchTarget_IN,
    input  logic        JumpRegFwd_IN,
    input  logic [31:0] JumpRegTarget_IN,
    input  logic        ExcReq_IN,
    output logic [31:0] AltPC_OUT,
    output logic        AltPCEnable_OUT,
    output logic        Flush_OUT,
    output logic        BranchAck_OUT,
    output logic        JumpRegAck_OUT,
    output logic        ExcAck_OUT,
    output logic        Pending_OUT,
    output logic        AddrErr_OUT
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } stateT;

    stateT            state, stateNext;
    logic [31:0]      altPc, altPcNext;
    logic             altPcEnable, enableNext;
    logic             pending, pendingNext;
    logic             flush, flushNext;
    logic [CNT_W-1:0] flushCnt, flushCntNext;
    logic             heldExc, heldExcNext;
    logic             branchAck, branchAckNext;
    logic             jrAck, jrAckNext;
    logic             excAck, excAckNext;

`ifdef REDIRECT_ALIGN_CHECK_EN
    logic addrErr, addrErrNext;

    function automatic logic isMisaligned(input logic [31:0] target);
        return target[1:0] != 2'b00;
    endfunction
`endif

    always_comb begin
        stateNext     = state;
        altPcNext     = altPc;
        enableNext    = altPcEnable;
        pendingNext   = pending;
        flushNext     = 1'b0;
        flushCntNext  = flushCnt;
        heldExcNext   = heldExc;
        branchAckNext = 1'b0;
        jrAckNext     = 1'b0;
        excAckNext    = 1'b0;
`ifdef REDIRECT_ALIGN_CHECK_EN
        addrErrNext   = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                // STALL does not gate capture; it only gates consumption in HOLD
                if (ExcReq_IN || JumpRegFwd_IN || BranchReq_IN) begin
                    stateNext   = HOLD;
                    enableNext  = 1'b1;
                    pendingNext = 1'b1;
                    if (ExcReq_IN) begin
                        altPcNext   = EXC_VECTOR;
                        heldExcNext = 1'b1;
                        excAckNext  = 1'b1;
                    end else begin
                        if (JumpRegFwd_IN) begin
                            altPcNext = JumpRegTarget_IN;
                            jrAckNext = 1'b1;
                        end else begin
                            altPcNext     = BranchTarget_IN;
                            branchAckNext = 1'b1;
                        end
                        heldExcNext = 1'b0;
`ifdef REDIRECT_ALIGN_CHECK_EN
                        if (isMisaligned(altPcNext)) begin
                            altPcNext   = EXC_VECTOR;
                            heldExcNext = 1'b1;
                            addrErrNext = 1'b1;
                        end
`endif
                    end
                end
            end
            HOLD: begin
                // An exception overrides a held branch/JR even when it would be consumed this edge
                if (ExcReq_IN && !heldExc) begin
                    altPcNext   = EXC_VECTOR;
                    heldExcNext = 1'b1;
                    excAckNext  = 1'b1;
                end else if (!STALL) begin
                    enableNext  = 1'b0;
                    pendingNext = 1'b0;
                    if (heldExc) begin
                        stateNext    = FLUSH;
                        flushNext    = 1'b1;
                        flushCntNext = CNT_W'(FLUSH_CYCLES - 1);
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            FLUSH: begin
                if (flushCnt == '0) begin
                    stateNext = IDLE;
                end else begin
                    flushNext    = 1'b1;
                    flushCntNext = flushCnt - CNT_W'(1);
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state       <= IDLE;
            altPc       <= '0;
            altPcEnable <= 1'b0;
            pending     <= 1'b0;
            flush       <= 1'b0;
            flushCnt    <= '0;
            heldExc     <= 1'b0;
            branchAck   <= 1'b0;
            jrAck       <= 1'b0;
            excAck      <= 1'b0;
        end else begin
            state       <= stateNext;
            altPc       <= altPcNext;
            altPcEnable <= enableNext;
            pending     <= pendingNext;
            flush       <= flushNext;
            flushCnt    <= flushCntNext;
            heldExc     <= heldExcNext;
            branchAck   <= branchAckNext;
            jrAck       <= jrAckNext;
            excAck      <= excAckNext;
        end
    end

`ifdef REDIRECT_ALIGN_CHECK_EN
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            addrErr <= 1'b0;
        end else begin
            addrErr <= addrErrNext;
        end
    end

    assign AddrErr_OUT = addrErr;
`else
    assign AddrErr_OUT = 1'b0;
`endif

    assign AltPC_OUT       = altPc;
    assign AltPCEnable_OUT = altPcEnable;
    assign Flush_OUT       = flush;
    assign BranchAck_OUT   = branchAck;
    assign JumpRegAck_OUT  = jrAck;
    assign ExcAck_OUT      = excAck;
    assign Pending_OUT     = pending;

endmodule
